// File: rtl/wb_ccd_seq_pkg.sv
// Purpose: shared constants and types for the CCD clock sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Register byte offsets, CTRL/STATUS bit positions and the FSM state type.
package wb_ccd_seq_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_DIV    = 8'h08;
  localparam logic [7:0] OFF_LEN    = 8'h0C;
  localparam logic [7:0] OFF_LINES  = 8'h10;
  localparam logic [7:0] OFF_IDLE   = 8'h14;
  localparam logic [7:0] OFF_PAT    = 8'h20;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_ONESHOT_BIT = 1;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;
  localparam int STAT_STEP_LSB  = 8;
  localparam int STAT_LINES_LSB = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // A programmed line count of 0 behaves like 1.
  function automatic logic [15:0] lines_target(input logic [15:0] lines);
    return (lines == 16'd0) ? 16'd1 : lines;
  endfunction

endpackage

// File: rtl/wb_ccd_seq_step_timer.sv
// Purpose: step-duration divider; counts down from div and fires tick at zero.
// Latency: tick is combinational from the count; one step lasts div+1 cycles.
// Backpressure: none; load has priority over counting.
//
// Ports: wb_clk_i/wb_rst_i clock and sync reset, load forces count=div,
// en advances the count, div reload value, tick high while count==0 and en.
module ccd_step_timer #(
  parameter int DIV_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == '0);

  // Reload samples div live, so a DIV edit lands at the next reload.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div;
    end else if (en) begin
      if (cnt == '0) cnt <= div;
      else           cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/wb_ccd_seq.sv
// Purpose: Wishbone-programmable CCD phase-clock sequencer (pattern table, per-step divider).
// Latency: bus ack/read data 1 cycle after access; o_phi follows the step register by 1 cycle.
// Backpressure: never stalls (wbs_sta_o=0); ack is single-cycle and never back-to-back.
//
// Ports: wb_clk_i/wb_rst_i clock and sync active-high reset; wbs_* caravel
// Wishbone slave; i_ext_en hardware enable gated with CTRL.EN; o_phi phase
// outputs (bit0 phi_p, 1 phi_l1, 2 phi_l2, 3 phi_r); o_busy in RUN;
// o_line_done one-cycle pulse per completed line.
module wb_ccd_seq
  import wb_ccd_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          N_PHASES     = 4,
  parameter int          STEPS        = 8,
  parameter int          DIV_W        = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic                wbs_sta_o,
  output logic [31:0]         wbs_dat_o,
  input  logic                i_ext_en,
  output logic [N_PHASES-1:0] o_phi,
  output logic                o_busy,
  output logic                o_line_done
);

  localparam int          STEP_W    = $clog2(STEPS);
  localparam logic [31:0] WIN_BYTES = 32'(32 + 4 * STEPS);

  // ---------------- state ----------------
  state_t              state;
  logic                ctrl_en;
  logic                ctrl_oneshot;
  logic                done;
  logic [DIV_W-1:0]    div_q;
  logic [STEP_W-1:0]   len_q;
  logic [15:0]         lines_q;
  logic [N_PHASES-1:0] idle_q;
  logic [N_PHASES-1:0] pat_q [STEPS];
  logic [STEP_W-1:0]   step;
  logic [15:0]         line_cnt;

  // ---------------- bus decode ----------------
  logic [31:0]       off;
  logic              in_win;
  logic              acc;
  logic              wr;
  logic [5:0]        word;
  logic [5:0]        pat_word;
  logic [STEP_W-1:0] pat_idx;
  logic              wr_ctrl;
  logic [STEP_W-1:0] len_wr;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign off      = wbs_adr_i - BASE_ADDRESS;
  assign in_win   = (wbs_adr_i >= BASE_ADDRESS) && (off < WIN_BYTES);
  // Gating with the current ack keeps a held strobe from being acked twice in a row.
  assign acc      = wbs_cyc_i && wbs_stb_i && !wbs_ack_o && in_win;
  assign wr       = acc && wbs_we_i;
  assign word     = off[7:2];
  assign pat_word = word - 6'(OFF_PAT[7:2]);
  assign pat_idx  = pat_word[STEP_W-1:0];
  assign wr_ctrl  = wr && (word == OFF_CTRL[7:2]);
  assign wbs_sta_o = 1'b0;

  // LEN is clamped when written, so reads return the value actually in use.
  assign len_wr = ({1'b0, wbs_dat_i[4:0]} >= 6'(STEPS)) ? STEP_W'(STEPS - 1)
                                                        : wbs_dat_i[STEP_W-1:0];

  assign unused_bits = ^{wbs_dat_i, pat_word};

  always_comb begin
    rdata = '0;
    case (word)
      OFF_CTRL[7:2]: begin
        rdata[CTRL_EN_BIT]      = ctrl_en;
        rdata[CTRL_ONESHOT_BIT] = ctrl_oneshot;
      end
      OFF_STATUS[7:2]: begin
        rdata[STAT_BUSY_BIT]                  = (state == ST_RUN);
        rdata[STAT_DONE_BIT]                  = done;
        rdata[STAT_STEP_LSB +: STEP_W]        = step;
        rdata[STAT_LINES_LSB +: 16]           = line_cnt;
      end
      OFF_DIV[7:2]:   rdata[DIV_W-1:0]    = div_q;
      OFF_LEN[7:2]:   rdata[STEP_W-1:0]   = len_q;
      OFF_LINES[7:2]: rdata[15:0]         = lines_q;
      OFF_IDLE[7:2]:  rdata[N_PHASES-1:0] = idle_q;
      default: begin
        if (word >= OFF_PAT[7:2]) rdata[N_PHASES-1:0] = pat_q[pat_idx];
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= (acc && !wbs_we_i) ? rdata : '0;
    end
  end

  // ---------------- sequencing ----------------
  logic        run_ok;
  logic        tick;
  logic        line_end;
  logic        finish;
  logic        restart_wr;
  logic        timer_load;
  logic [15:0] new_lines;

  assign run_ok     = ctrl_en && i_ext_en;
  // ">=" rather than "==" so a LEN edited below the live step wraps on the next tick.
  assign line_end   = tick && (step >= len_q);
  assign new_lines  = (line_cnt == 16'hFFFF) ? line_cnt : line_cnt + 16'd1;
  assign finish     = (state == ST_RUN) && run_ok && line_end && ctrl_oneshot &&
                      (new_lines == lines_target(lines_q));
  // A CTRL write setting EN in the terminating cycle restarts instead of stopping.
  assign restart_wr = wr_ctrl && wbs_dat_i[CTRL_EN_BIT];
  assign timer_load = ((state == ST_IDLE) && run_ok) || (finish && restart_wr);
  assign o_busy     = (state == ST_RUN);

  ccd_step_timer #(
    .DIV_W (DIV_W)
  ) u_step_timer (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .load     (timer_load),
    .en       (state == ST_RUN),
    .div      (div_q),
    .tick     (tick)
  );

  // Register file and FSM share one process because both own CTRL.EN and done.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= ST_IDLE;
      ctrl_en      <= 1'b0;
      ctrl_oneshot <= 1'b0;
      done         <= 1'b0;
      div_q        <= '0;
      len_q        <= '0;
      lines_q      <= '0;
      idle_q       <= '0;
      step         <= '0;
      line_cnt     <= '0;
      o_phi        <= '0;
      o_line_done  <= 1'b0;
      for (int i = 0; i < STEPS; i++) pat_q[i] <= '0;
    end else begin
      o_line_done <= 1'b0;

      if (wr) begin
        case (word)
          OFF_CTRL[7:2]: begin
            ctrl_en      <= wbs_dat_i[CTRL_EN_BIT];
            ctrl_oneshot <= wbs_dat_i[CTRL_ONESHOT_BIT];
            done         <= 1'b0;
          end
          OFF_DIV[7:2]:   div_q   <= wbs_dat_i[DIV_W-1:0];
          OFF_LEN[7:2]:   len_q   <= len_wr;
          OFF_LINES[7:2]: lines_q <= wbs_dat_i[15:0];
          OFF_IDLE[7:2]:  idle_q  <= wbs_dat_i[N_PHASES-1:0];
          default: begin
            if (word >= OFF_PAT[7:2]) pat_q[pat_idx] <= wbs_dat_i[N_PHASES-1:0];
          end
        endcase
      end

      case (state)
        ST_IDLE: begin
          o_phi <= idle_q;
          if (run_ok) begin
            state    <= ST_RUN;
            step     <= '0;
            line_cnt <= '0;
            done     <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!run_ok) begin
            // Partial line is dropped silently.
            state <= ST_IDLE;
            o_phi <= idle_q;
          end else begin
            o_phi <= pat_q[step];
            if (tick) begin
              if (line_end) begin
                step        <= '0;
                o_line_done <= 1'b1;
                line_cnt    <= new_lines;
                if (finish) begin
                  if (restart_wr) begin
                    line_cnt <= '0;
                    done     <= 1'b0;
                  end else begin
                    state   <= ST_IDLE;
                    ctrl_en <= 1'b0;
                    done    <= 1'b1;
                    o_phi   <= idle_q;
                  end
                end
              end else begin
                step <= step + STEP_W'(1);
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ccd_seq.sv
// Purpose: directed self-checking bench for wb_ccd_seq (8 phases, 16 steps).
// Latency: all samples taken 1 ns after the rising edge.
// Backpressure: bus helpers wait at most 4 cycles for ack.
module tb_wb_ccd_seq;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          NP   = 8;
  localparam int          ST   = 16;

  logic          clk;
  logic          rst;
  logic          cyc;
  logic          stb;
  logic          we;
  logic [31:0]   adr;
  logic [31:0]   dat_w;
  logic          ack;
  logic          sta;
  logic [31:0]   dat_r;
  logic          ext_en;
  logic [NP-1:0] phi;
  logic          busy;
  logic          line_done;

  int vectors;
  int miscompares;

  wb_ccd_seq #(
    .BASE_ADDRESS (BASE),
    .N_PHASES     (NP),
    .STEPS        (ST),
    .DIV_W        (16)
  ) u_dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (dat_w),
    .wbs_ack_o   (ack),
    .wbs_sta_o   (sta),
    .wbs_dat_o   (dat_r),
    .i_ext_en    (ext_en),
    .o_phi       (phi),
    .o_busy      (busy),
    .o_line_done (line_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  // Returns at the sample point just after the edge that raised ack.
  task automatic bus_write(input logic [7:0] off, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'(off); dat_w = d;
    for (int i = 0; i < 4; i++) begin
      tick1();
      if (ack) break;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic acked);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    d = '0; acked = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick1();
      if (ack) begin
        d = dat_r; acked = 1'b1;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        a;
    rst = 1'b1;
    repeat (3) tick1();
    vectors++;
    if ({phi, busy, line_done, ack, sta} !== '0 || dat_r !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: phi=%h busy=%b ld=%b ack=%b sta=%b dat=%h, required all 0",
               phi, busy, line_done, ack, sta, dat_r);
    end
    rst = 1'b0;
    tick1();
    bus_read(BASE + 32'h04, d, a);
    vectors++;
    if (a !== 1'b1 || d !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_status: ack=%b data=%h, required ack=1 data=0", a, d);
    end
    bus_read(BASE + 32'h14, d, a);
    vectors++;
    if (a !== 1'b1 || d !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_idle: ack=%b data=%h, required ack=1 data=0", a, d);
    end
  endtask

  task automatic test_idle();
    logic [31:0] d;
    logic        a;
    bus_write(8'h14, 32'h9);
    repeat (2) tick1();
    vectors++;
    if (phi !== 8'h09) begin
      miscompares++;
      $display("FAIL idle_phi: phi=%h, required 09", phi);
    end
    bus_read(BASE + 32'h14, d, a);
    vectors++;
    if (d !== 32'h9) begin
      miscompares++;
      $display("FAIL idle_readback: data=%h, required 00000009", d);
    end
  endtask

  task automatic test_run();
    logic [NP-1:0] exp_phi;
    logic          exp_ld;
    bus_write(8'h20, 32'h1);
    bus_write(8'h24, 32'h2);
    bus_write(8'h28, 32'h4);
    bus_write(8'h2C, 32'h8);
    bus_write(8'h0C, 32'd3);
    bus_write(8'h08, 32'd2);
    bus_write(8'h00, 32'h1);
    // k counts edges after the CTRL write edge: RUN at k=1, first pattern at k=2,
    // three cycles per step, line wraps at k=13 and k=25.
    for (int k = 1; k <= 26; k++) begin
      tick1();
      exp_ld = (k == 13) || (k == 25);
      vectors++;
      if (line_done !== exp_ld || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL run_line_done k=%0d: ld=%b busy=%b, required ld=%b busy=1", k, line_done, busy, exp_ld);
      end
      if (k >= 2) begin
        exp_phi = NP'(1) << (((k - 2) / 3) % 4);
        vectors++;
        if (phi !== exp_phi) begin
          miscompares++;
          $display("FAIL run_phi k=%0d: phi=%h, required %h", k, phi, exp_phi);
        end
      end
    end
    bus_write(8'h00, 32'h0);
    repeat (2) tick1();
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic        a;
    int          pulses;
    pulses = 0;
    bus_write(8'h10, 32'd2);
    bus_write(8'h0C, 32'd1);
    bus_write(8'h08, 32'd0);
    bus_write(8'h00, 32'h3);
    for (int k = 1; k <= 12; k++) begin
      tick1();
      if (line_done) pulses++;
      if (k == 4 || k == 5) begin
        vectors++;
        if (busy !== (k == 4)) begin
          miscompares++;
          $display("FAIL oneshot_busy k=%0d: busy=%b, required %b", k, busy, (k == 4));
        end
      end
    end
    vectors++;
    if (pulses != 2 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL oneshot_pulses: pulses=%0d busy=%b, required 2 and 0", pulses, busy);
    end
    bus_read(BASE + 32'h04, d, a);
    vectors++;
    if (d !== 32'h0002_0002) begin
      miscompares++;
      $display("FAIL oneshot_status: data=%h, required 00020002", d);
    end
    bus_read(BASE + 32'h00, d, a);
    vectors++;
    if (d !== 32'h2) begin
      miscompares++;
      $display("FAIL oneshot_ctrl: data=%h, required 00000002", d);
    end
  endtask

  task automatic test_ext_drop();
    logic [31:0] d;
    logic        a;
    int          pulses;
    pulses = 0;
    bus_write(8'h08, 32'd2);
    bus_write(8'h0C, 32'd3);
    bus_write(8'h00, 32'h1);
    repeat (6) tick1();
    vectors++;
    if (phi !== 8'h02) begin
      miscompares++;
      $display("FAIL drop_pre_phi: phi=%h, required 02", phi);
    end
    ext_en = 1'b0;
    tick1();
    vectors++;
    if (busy !== 1'b0 || phi !== 8'h09 || line_done !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_exit: busy=%b phi=%h ld=%b, required 0/09/0", busy, phi, line_done);
    end
    for (int k = 0; k < 15; k++) begin
      tick1();
      if (line_done) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL drop_no_pulse: pulses=%0d, required 0", pulses);
    end
    ext_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick1();
      if (k == 1) begin
        vectors++;
        if (busy !== 1'b1 || phi !== 8'h09) begin
          miscompares++;
          $display("FAIL drop_restart k=1: busy=%b phi=%h, required 1/09", busy, phi);
        end
      end else if (k == 2 || k == 4 || k == 5) begin
        vectors++;
        if (phi !== ((k == 5) ? 8'h02 : 8'h01)) begin
          miscompares++;
          $display("FAIL drop_restart k=%0d: phi=%h, required %h", k, phi, (k == 5) ? 8'h02 : 8'h01);
        end
      end
    end
    bus_read(BASE + 32'h04, d, a);
    vectors++;
    if (d[31:16] !== 16'h0 || d[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_status: data=%h, required busy=1 lines=0", d);
    end
    bus_write(8'h00, 32'h0);
    repeat (2) tick1();
  endtask

  task automatic test_bus();
    logic [31:0] d;
    logic        a;
    logic        exp_ack;
    bus_read(BASE + 32'h18, d, a);
    vectors++;
    if (a !== 1'b1 || d !== 32'h0) begin
      miscompares++;
      $display("FAIL bus_unmapped: ack=%b data=%h, required 1/0", a, d);
    end
    bus_read(BASE + 32'h1000, d, a);
    vectors++;
    if (a !== 1'b0) begin
      miscompares++;
      $display("FAIL bus_far: ack=%b, required 0", a);
    end
    bus_read(BASE + 32'h60, d, a);
    vectors++;
    if (a !== 1'b0) begin
      miscompares++;
      $display("FAIL bus_window_end: ack=%b, required 0", a);
    end
    bus_read(BASE + 32'h5C, d, a);
    vectors++;
    if (a !== 1'b1) begin
      miscompares++;
      $display("FAIL bus_last_pat: ack=%b, required 1", a);
    end
    tick1();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h14;
    for (int k = 1; k <= 8; k++) begin
      tick1();
      exp_ack = (k % 2) == 1;
      vectors++;
      if (ack !== exp_ack || (ack && dat_r !== 32'h9)) begin
        miscompares++;
        $display("FAIL bus_b2b k=%0d: ack=%b data=%h, required ack=%b data=09", k, ack, dat_r, exp_ack);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    tick1();
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d;
    logic        a;
    bus_write(8'h00, 32'h1);
    repeat (5) tick1();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstrun_pre: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    tick1();
    vectors++;
    if (phi !== '0 || busy !== 1'b0 || line_done !== 1'b0 || ack !== 1'b0 || dat_r !== 32'h0) begin
      miscompares++;
      $display("FAIL rstrun_outputs: phi=%h busy=%b ld=%b ack=%b dat=%h, required all 0",
               phi, busy, line_done, ack, dat_r);
    end
    rst = 1'b0;
    tick1();
    bus_read(BASE + 32'h00, d, a);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL rstrun_ctrl: data=%h, required 0", d);
    end
    bus_read(BASE + 32'h08, d, a);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL rstrun_div: data=%h, required 0", d);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] d;
    logic        a;
    bus_write(8'h5C, 32'hA5);
    bus_write(8'h0C, 32'd20);
    bus_read(BASE + 32'h0C, d, a);
    vectors++;
    if (d !== 32'd15) begin
      miscompares++;
      $display("FAIL sweep_len_clamp: data=%h, required 0000000f", d);
    end
    bus_read(BASE + 32'h5C, d, a);
    vectors++;
    if (d !== 32'hA5) begin
      miscompares++;
      $display("FAIL sweep_pat15: data=%h, required 000000a5", d);
    end
    bus_write(8'h00, 32'h1);
    // DIV=0: one step per cycle, step 15 selected at k=16, driven at k=17.
    for (int k = 1; k <= 18; k++) begin
      tick1();
      if (k >= 16) begin
        vectors++;
        if (phi !== ((k == 17) ? 8'hA5 : 8'h00) || line_done !== (k == 17)) begin
          miscompares++;
          $display("FAIL sweep_step15 k=%0d: phi=%h ld=%b, required %h/%b",
                   k, phi, line_done, (k == 17) ? 8'hA5 : 8'h00, (k == 17));
        end
      end
    end
    bus_write(8'h00, 32'h0);
    repeat (2) tick1();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat_w = '0; ext_en = 1'b1;
    test_reset();
    test_idle();
    test_run();
    test_oneshot();
    test_ext_drop();
    test_bus();
    test_reset_mid_run();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_ccd_seq.md
Name: wb_ccd_seq

Overview:
Wishbone-programmable CCD clock sequencer generating N_PHASES phase clocks from a table of up to STEPS patterns. Each step is held for a programmable number of wb_clk_i cycles. Lines repeat continuously, or a programmed count of times in one-shot mode. Sits on the caravel-style user Wishbone bus and drives the CCD phase pins (phi_p, phi_l1, phi_l2, phi_r, and extra phases).

Parameters:
BASE_ADDRESS, 32'h3000_0000, base of the register window
N_PHASES, 4, number of phase outputs (1..16)
STEPS, 8, pattern table depth (power of 2, 2..32)
DIV_W, 16, width of the step-duration divider

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
wbs_cyc_i  in  1  bus cycle
wbs_stb_i  in  1  strobe
wbs_we_i  in  1  write enable
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  transfer acknowledge
wbs_sta_o  out  1  stall, tied 0
wbs_dat_o  out  32  read data
i_ext_en  in  1  hardware enable, ANDed with CTRL.EN
o_phi  out  N_PHASES  phase clocks; bit0 = phi_p, 1 = phi_l1, 2 = phi_l2, 3 = phi_r
o_busy  out  1  sequencer in RUN
o_line_done  out  1  one-cycle pulse at end of each line

Behaviour:
- Single clock wb_clk_i. Reset wb_rst_i is synchronous, active-high.
- Reset values: all registers 0, state IDLE, o_phi=0, o_busy=0, o_line_done=0, wbs_ack_o=0, wbs_dat_o=0.
- Register map (offset from BASE_ADDRESS):
  - +0x00 CTRL RW: [0] EN, [1] ONESHOT.
  - +0x04 STATUS RO: [0] busy, [1] done (sticky, cleared by a CTRL write), [12:8] step index, [31:16] line count.
  - +0x08 DIV RW [DIV_W-1:0].
  - +0x0C LEN RW [4:0]: last step index. Values >= STEPS are clamped to STEPS-1.
  - +0x10 LINES RW [15:0]: one-shot line count; 0 is treated as 1.
  - +0x14 IDLE RW [N_PHASES-1:0]: pattern driven when not running.
  - +0x20 + 4*i PAT[i] RW [N_PHASES-1:0], for i < STEPS.
  - Unused bits read 0 and are ignored on write.
- Bus access:
  - Access = cyc & stb.
  - wbs_ack_o asserts the cycle after an access whose address lies in [BASE, BASE+0x20+4*STEPS). It is held for one cycle, and is never asserted two cycles in a row (no re-ack while ack is high).
  - Out-of-window addresses get no ack.
  - Reads return data registered in the same edge as ack. In-window unmapped offsets read 0.
  - Writes take effect on the edge that raises ack.
- Step divider: divcnt counts down from DIV. A tick fires when divcnt==0 and reloads DIV. DIV=0 gives one step per cycle; step duration is DIV+1 cycles.
- FSM:
  - IDLE: o_phi = IDLE reg, registered. When EN & i_ext_en: go to RUN, step=0, divcnt=DIV, line count=0, done=0.
  - RUN: o_phi = PAT[step], registered, so o_phi changes one cycle after the step changes. On a tick:
    - if step != LEN: step+1.
    - else: step=0, o_line_done=1 for one cycle, line count+1 (saturates at 0xFFFF).
    - if ONESHOT and the new line count == max(LINES,1): go to IDLE, clear CTRL.EN, set done.
  - Leaving RUN: EN=0 or i_ext_en=0 goes to IDLE on the next edge, discarding the partial line without a line_done pulse.
- Live edits: PAT/DIV/LEN writes during RUN are allowed. PAT takes effect at its next selection. DIV takes effect at the next reload. A LEN below the current step causes wrap at the next tick.
- Simultaneous events: a CTRL write with EN=1 in the same cycle the one-shot terminates wins; the sequencer restarts.
- Reset mid-RUN returns everything to reset values on the next edge.

Decomposition:
- Package wb_ccd_seq_pkg holds register offset constants, CTRL/STATUS bit positions, and the FSM state enum (IDLE, RUN).
- One sub-module, ccd_step_timer: divider counter with load/tick, parametrised by DIV_W.
- Register file and FSM stay in the top level.

Test Plan:
- Reset, then read STATUS and IDLE -> 0. Write IDLE=4'b1001 -> o_phi=4'b1001 two cycles after ack.
- PAT0..3 = 1,2,4,8, LEN=3, DIV=2, CTRL=1 -> o_phi cycles 1,2,4,8 with 3 cycles per step. o_line_done pulses every 12 cycles.
- ONESHOT, LINES=2, LEN=1, DIV=0, CTRL=3 -> exactly 2 line_done pulses, then busy=0, STATUS.done=1, CTRL reads 2.
- Drop i_ext_en mid-line -> next edge busy=0, o_phi=IDLE, no line_done pulse. Raise i_ext_en -> restart at step 0.
- Read offset 0x18 -> ack with 0. Read BASE+0x1000 -> no ack. Back-to-back stb -> ack never high two consecutive cycles.
- Assert wb_rst_i during RUN -> all outputs 0 next edge. Sweep N_PHASES=8, STEPS=16 -> PAT[15] reachable, LEN=20 clamps to 15.
